i2s_tx_source: RTL

//  Upstream companion of the I2S serializer. Divides clk into bclk and lrclk and buffers stereo frames

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_frame_fifo.sv | 54 +++++
 rtl/i2s_tx_source.sv | 127 ++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared types and encodings for the I2S transmit source.
package i2s_pkg;

  localparam int W_SER_DEF = 16;

  // lrclk encoding: which channel slot is currently on the wire
  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  // Default stereo frame; the top rebuilds this with its own w_ser
  typedef struct packed {
    logic [W_SER_DEF-1:0] left;
    logic [W_SER_DEF-1:0] right;
  } frame_t;

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous show-ahead FIFO of stereo frames. The head word is visible on dout
// whenever empty is low; full/empty/level come from the registered occupancy count.
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int  fifo_depth = 4,
  parameter type elem_t     = frame_t,
  localparam int AW         = $clog2(fifo_depth)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  elem_t       din,
  output elem_t       dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(fifo_depth);

  elem_t         mem [fifo_depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  // Storage array: data only, discarded logically by the pointer reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally (depth is a power of two); level tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_source.sv
// I2S transmit source: generates bclk/lrclk from clk, buffers stereo frames and
// presents each channel word on `sample` mid-slot so it is stable around either
// lrclk edge. An empty FIFO at the frame load point plays silence and pulses underrun.
module i2s_tx_source
  import i2s_pkg::*;
#(
  parameter int  w_ser      = 16,
  parameter int  bclk_div   = 4,
  parameter int  slot_bits  = 16,
  parameter int  fifo_depth = 4,
  localparam int LW         = $clog2(fifo_depth) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [w_ser-1:0] s_left,
  input  logic signed [w_ser-1:0] s_right,
  output logic                    bclk,
  output logic                    lrclk,
  output logic signed [w_ser-1:0] sample,
  output logic                    underrun,
  output logic [LW-1:0]           fifo_level
);

  localparam int DW = (bclk_div > 1) ? $clog2(bclk_div) : 1;
  localparam int BW = $clog2(slot_bits);
  localparam logic [DW-1:0] DIV_LAST = DW'(bclk_div - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(slot_bits - 1);
  localparam logic [BW-1:0] BIT_MID  = BW'(slot_bits / 2);

  typedef struct packed {
    logic [w_ser-1:0] left;
    logic [w_ser-1:0] right;
  } frame_w_t;

  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt;
  logic signed [w_ser-1:0] hold;
  logic                    div_tc;
  logic                    bclk_rise;
  logic                    bclk_fall;
  logic                    load_pt;
  logic                    load_right;
  logic                    load_left;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  frame_w_t                fifo_din;
  frame_w_t                fifo_head;

  assign div_tc     = (div_cnt == DIV_LAST);
  assign bclk_rise  = div_tc && !bclk;
  assign bclk_fall  = div_tc && bclk;
  assign load_pt    = bclk_rise && (bit_cnt == BIT_MID);
  assign load_right = load_pt && (lrclk == LR_RIGHT);
  assign load_left  = load_pt && (lrclk == LR_LEFT);
  assign fifo_pop   = load_right && !fifo_empty;
  assign fifo_din   = '{left: s_left, right: s_right};
  assign s_ready    = !fifo_full;

  i2s_frame_fifo #(
    .fifo_depth (fifo_depth),
    .elem_t     (frame_w_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // bclk divider: toggle every bclk_div clk cycles, first toggle is a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Bit position within the slot; lrclk flips on the slot's last bclk fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      lrclk   <= LR_LEFT;
    end else if (bclk_fall) begin
      if (bit_cnt == BIT_LAST) begin
        bit_cnt <= '0;
        lrclk   <= ~lrclk;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Mid-slot loads: right slot fetches a new frame (or silence), left slot replays the held right word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample   <= '0;
      hold     <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= load_right && fifo_empty;
      if (load_right) begin
        if (!fifo_empty) begin
          sample <= fifo_head.left;
          hold   <= fifo_head.right;
        end else begin
          sample <= '0;
          hold   <= '0;
        end
      end else if (load_left) begin
        sample <= hold;
      end
    end
  end

endmodule
